vectored_int_sequencer: RTL and testbench

Sequential front end for the vectored interrupt path. It captures rising edges on the four peripheral `done` lines into a pending register and applies a software mask. It raises a single request to the CPU, and on the CPU's acknowledge it latches the highest-priority eligible source and drives the matching vector address, holding it until the handler signals end-of-interrupt. Priority and vector encoding match the existing vectored interrupt map: done4 is highest, and the address is {28'hFFFFFFF, idx[1:0], 2'b00}.

---
 rtl/vectored_int_sequencer.sv | 105 ++++++++++
 tb/tb_vectored_int_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vectored_int_sequencer.sv
// Vectored interrupt sequencer: captures done-line rising edges, masks them,
// and runs a single request/acknowledge/end-of-interrupt handshake to the CPU.
module vectored_int_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        done1,
  input  logic        done2,
  input  logic        done3,
  input  logic        done4,
  input  logic        int_ack,
  input  logic        eoi,
  input  logic        mask_we,
  input  logic [3:0]  mask_wd,
  output logic        int_req,
  output logic [31:0] int_addr,
  output logic        in_service,
  output logic [3:0]  pending,
  output logic [3:0]  mask
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  done_vec;
  logic [3:0]  done_prev_q, done_prev_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] int_addr_q, int_addr_d;
  logic        int_req_q, int_req_d;
  logic        in_service_q, in_service_d;
  logic [3:0]  rise;
  logic [3:0]  eligible;
  logic [1:0]  idx;

  assign done_vec = {done4, done3, done2, done1};
  assign rise     = done_vec & ~done_prev_q;
  assign eligible = pending_q & mask_q;

  // Fixed priority: done4 wins over everything below it.
  always_comb begin
    idx = 2'd0;
    if (eligible[3])      idx = 2'd3;
    else if (eligible[2]) idx = 2'd2;
    else if (eligible[1]) idx = 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    int_addr_d  = int_addr_q;
    done_prev_d = done_vec;
    mask_d      = mask_we ? mask_wd : mask_q;

    case (state_q)
      IDLE: begin
        if (|eligible) state_d = REQ;
      end
      REQ: begin
        if (~|eligible) begin
          state_d = IDLE;
        end else if (int_ack) begin
          state_d         = SERVICE;
          int_addr_d      = {28'hFFFFFFF, idx, 2'b00};
          pending_d[idx]  = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the acked source re-arms it: set beats clear.
    pending_d    = pending_d | rise;
    int_req_d    = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      done_prev_q  <= 4'b0000;
      pending_q    <= 4'b0000;
      mask_q       <= 4'b1111;
      int_addr_q   <= 32'hFFFF_FFF0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_prev_q  <= done_prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_addr_q   <= int_addr_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_addr   = int_addr_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_vectored_int_sequencer.sv
// Bench for vectored_int_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_vectored_int_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dn;
  logic        int_ack, eoi, mask_we;
  logic [3:0]  mask_wd;
  logic        int_req, in_service;
  logic [31:0] int_addr;
  logic [3:0]  pending, mask;

  int checks = 0;
  int errs   = 0;

  vectored_int_sequencer dut (
    .clk(clk), .rst(rst),
    .done1(dn[0]), .done2(dn[1]), .done3(dn[2]), .done4(dn[3]),
    .int_ack(int_ack), .eoi(eoi), .mask_we(mask_we), .mask_wd(mask_wd),
    .int_req(int_req), .int_addr(int_addr), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two flags describe where the handshake is.
  bit         m_req, m_svc;
  bit [3:0]   m_pend, m_mask, m_prev;
  bit [31:0]  m_addr;

  task automatic model_step();
    bit [3:0] rise, elig, np;
    int win;
    if (rst) begin
      m_req = 0; m_svc = 0; m_pend = 0; m_mask = 4'hF; m_prev = 0;
      m_addr = 32'hFFFF_FFF0;
      return;
    end
    rise = dn & ~m_prev;
    elig = m_pend & m_mask;
    win = -1;
    for (int i = 0; i < 4; i++) if (elig[i]) win = i;
    np = m_pend;
    if (m_req) begin
      if (elig == 0) m_req = 0;
      else if (int_ack) begin
        m_req = 0;
        m_svc = 1;
        m_addr = 32'hFFFF_FFF0 + 32'(4 * win);
        np[win] = 1'b0;
      end
    end else if (m_svc) begin
      if (eoi) m_svc = 0;
    end else if (elig != 0) begin
      m_req = 1;
    end
    m_pend = np | rise;
    if (mask_we) m_mask = mask_wd;
    m_prev = dn;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("m_int_req",    {31'b0, int_req},    {31'b0, m_req});
      check("m_in_service", {31'b0, in_service}, {31'b0, m_svc});
      check("m_pending",    {28'b0, pending},    {28'b0, m_pend});
      check("m_mask",       {28'b0, mask},       {28'b0, m_mask});
      check("m_int_addr",   int_addr,            m_addr);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic ack();
    int_ack = 1; step(); int_ack = 0;
  endtask

  task automatic end_int();
    eoi = 1; step(); eoi = 0;
  endtask

  task automatic pulse(input int b);
    dn[b] = 1'b1; step(); dn[b] = 1'b0;
  endtask

  initial begin
    rst = 1; dn = 0; int_ack = 0; eoi = 0; mask_we = 0; mask_wd = 0;
    step(); step();
    check("rst_req",  {31'b0, int_req}, 0);
    check("rst_svc",  {31'b0, in_service}, 0);
    check("rst_pend", {28'b0, pending}, 0);
    check("rst_mask", {28'b0, mask}, 32'hF);
    check("rst_addr", int_addr, 32'hFFFF_FFF0);
    rst = 0; step();

    // Single source on done2.
    pulse(1);
    check("s_pend", {28'b0, pending}, 32'h2);
    check("s_req0", {31'b0, int_req}, 0);
    step();
    check("s_req1", {31'b0, int_req}, 1);
    ack();
    check("s_addr", int_addr, 32'hFFFF_FFF4);
    check("s_pend0", {28'b0, pending}, 0);
    check("s_svc", {31'b0, in_service}, 1);
    check("s_reqlow", {31'b0, int_req}, 0);
    end_int();
    check("s_eoi_svc", {31'b0, in_service}, 0);
    step();
    check("s_idle_req", {31'b0, int_req}, 0);

    // Priority: done1 and done3 together.
    dn = 4'b0101; step(); dn = 0; step();
    ack();
    check("p_addr", int_addr, 32'hFFFF_FFF8);
    check("p_pend", {28'b0, pending}, 32'h1);
    end_int();
    check("p_req_k", {31'b0, int_req}, 0);
    step();
    check("p_req_k1", {31'b0, int_req}, 1);
    ack();
    check("p_addr2", int_addr, 32'hFFFF_FFF0);
    end_int();

    // Masking of done4.
    mask_we = 1; mask_wd = 4'b0111; step(); mask_we = 0;
    pulse(3);
    check("m_pend8", {28'b0, pending}, 32'h8);
    step();
    check("m_req_masked", {31'b0, int_req}, 0);
    mask_we = 1; mask_wd = 4'b1111; step(); mask_we = 0;
    check("m_req_still0", {31'b0, int_req}, 0);
    step();
    check("m_req_unmask", {31'b0, int_req}, 1);
    ack();
    check("m_addr", int_addr, 32'hFFFF_FFFC);
    end_int();
    step();

    // Stray handshakes and mask retraction.
    ack();
    check("x_ack_idle", {31'b0, int_req}, 0);
    check("x_ack_svc", {31'b0, in_service}, 0);
    pulse(0); step();
    end_int();
    check("x_eoi_req", {31'b0, int_req}, 1);
    mask_we = 1; mask_wd = 4'b1110; step(); mask_we = 0;
    check("x_req_hold", {31'b0, int_req}, 1);
    ack();
    check("x_retract_req", {31'b0, int_req}, 0);
    check("x_retract_svc", {31'b0, in_service}, 0);
    check("x_retract_addr", int_addr, 32'hFFFF_FFFC);
    check("x_retract_pend", {28'b0, pending}, 32'h1);
    mask_we = 1; mask_wd = 4'b1111; step(); mask_we = 0;
    step(); ack(); end_int(); step();

    // Set/clear race on done4.
    pulse(3); step();
    dn[3] = 1; int_ack = 1; step(); dn[3] = 0; int_ack = 0;
    check("r_addr", int_addr, 32'hFFFF_FFFC);
    check("r_pend", {28'b0, pending}, 32'h8);
    end_int(); step();
    check("r_req2", {31'b0, int_req}, 1);
    ack(); end_int(); step();

    // Reset mid-service with done3 held high.
    pulse(1); step(); ack();
    check("z_svc", {31'b0, in_service}, 1);
    rst = 1; dn[2] = 1; step();
    check("z_svc0", {31'b0, in_service}, 0);
    check("z_pend0", {28'b0, pending}, 0);
    check("z_addr", int_addr, 32'hFFFF_FFF0);
    rst = 0; step();
    check("z_pend4", {28'b0, pending}, 32'h4);
    dn = 0; step();
    check("z_req", {31'b0, int_req}, 1);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) dn[b] = ~dn[b];
      int_ack = ($urandom_range(0, 9) < 3);
      eoi     = ($urandom_range(0, 9) < 2);
      mask_we = ($urandom_range(0, 9) == 0);
      mask_wd = 4'($urandom_range(0, 15));
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; int_ack = 0; eoi = 0; mask_we = 0; dn = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
